// File: rtl/cam_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// cam_cfg_sequencer
//
// Walks the camera sensor register table held in an external synchronous ROM
// and issues one I2C register write per entry through the existing driver.
// Each table entry is {reg[15:0], data[7:0]}. reg == 16'hFFFF marks a delay
// entry of data * DELAY_TICKS clock cycles. A write that is NACKed, or whose
// driver never raises busy, is retried up to MAX_RETRY extra times. After
// that the run stops with cfg_fail and the failing index.
//
// Ports
//   clk_i            I2C control clock (single clock domain)
//   rst_n            synchronous active-low reset
//   cfg_start        run request; a rising edge in IDLE/DONE/FAIL starts a run
//   rom_addr         table ROM read address
//   rom_data         table ROM data, one cycle after rom_addr
//   i2c_device_addr  constant device address for the driver
//   wr_rd_flag       constant 0 (write) for the driver
//   register         register address for the driver
//   data_byte        write data for the driver
//   start_en         one-cycle transaction start pulse for the driver
//   busy             driver busy
//   err              driver NACK flag, valid when busy falls
//   cfg_busy         run in progress
//   cfg_done         sticky, table completed
//   cfg_fail         sticky, an entry ran out of retries
//   fail_index       failing entry index, 0 unless cfg_fail
//
// Assumes GAP_CYCLES >= 1, BUSY_TIMEOUT >= 1 and DELAY_TICKS >= 1.
// ---------------------------------------------------------------------------
module cam_cfg_sequencer #(
  parameter logic [7:0] DEV_ADDR     = 8'h78,
  parameter int         NUM_ENTRIES  = 16,
  parameter int         ADDR_W       = 8,
  parameter int         MAX_RETRY    = 3,
  parameter int         DELAY_TICKS  = 800,
  parameter int         BUSY_TIMEOUT = 64,
  parameter int         GAP_CYCLES   = 4
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              cfg_start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic [7:0]        i2c_device_addr,
  output logic              wr_rd_flag,
  output logic [15:0]       register,
  output logic [7:0]        data_byte,
  output logic              start_en,
  input  logic              busy,
  input  logic              err,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_fail,
  output logic [ADDR_W-1:0] fail_index
);

  // The delay counter must hold 255 * DELAY_TICKS without overflow.
  localparam int DLY_W = 8 + $clog2(DELAY_TICKS);
  localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_ENTRIES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);
  localparam logic [DLY_W-1:0]  DLY_TICKS = DLY_W'(DELAY_TICKS);
  localparam logic [15:0]       DELAY_REG = 16'hFFFF;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_LATCH   = 4'd2,
    S_DECODE  = 4'd3,
    S_ISSUE   = 4'd4,
    S_WAIT_HI = 4'd5,
    S_WAIT_LO = 4'd6,
    S_CHECK   = 4'd7,
    S_GAP     = 4'd8,
    S_DELAY   = 4'd9,
    S_NEXT    = 4'd10,
    S_DONE    = 4'd11,
    S_FAIL    = 4'd12
  } state_t;

  state_t            state_q;
  logic              start_prev_q;
  logic [ADDR_W-1:0] idx_q;
  logic [23:0]       ent_q;
  logic [RTY_W-1:0]  retry_q;
  logic [DLY_W-1:0]  dly_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic              gap_retry_q;   // GAP exits to ISSUE (retry) rather than NEXT
  logic              err_flag_q;

  logic [ADDR_W-1:0] rom_addr_q;
  logic [15:0]       register_q;
  logic [7:0]        data_byte_q;
  logic              start_en_q;
  logic              cfg_busy_q;
  logic              cfg_done_q;
  logic              cfg_fail_q;
  logic [ADDR_W-1:0] fail_index_q;

  logic              start_edge;
  logic [DLY_W-1:0]  dly_load_d;
  logic [ADDR_W-1:0] idx_inc_d;

  // Start edge detection, delay length and next index.
  always_comb begin
    start_edge = cfg_start & ~start_prev_q;
    dly_load_d = DLY_W'(ent_q[7:0]) * DLY_TICKS;
    idx_inc_d  = idx_q + ADDR_W'(1);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      idx_q        <= '0;
      ent_q        <= '0;
      retry_q      <= '0;
      dly_q        <= '0;
      to_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      gap_retry_q  <= 1'b0;
      err_flag_q   <= 1'b0;
      rom_addr_q   <= '0;
      register_q   <= '0;
      data_byte_q  <= '0;
      start_en_q   <= 1'b0;
      cfg_busy_q   <= 1'b0;
      cfg_done_q   <= 1'b0;
      cfg_fail_q   <= 1'b0;
      fail_index_q <= '0;
    end else begin
      start_prev_q <= cfg_start;
      // start_en is raised on entry to ISSUE so it is high only while in ISSUE.
      start_en_q   <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start_edge) begin
            idx_q        <= '0;
            // Address is presented ahead of FETCH so the ROM output is
            // already valid by the LATCH cycle.
            rom_addr_q   <= '0;
            cfg_done_q   <= 1'b0;
            cfg_fail_q   <= 1'b0;
            fail_index_q <= '0;
            cfg_busy_q   <= 1'b1;
            state_q      <= S_FETCH;
          end else begin
            state_q <= state_q;
          end
        end
        S_FETCH: begin
          rom_addr_q <= idx_q;
          state_q    <= S_LATCH;
        end
        S_LATCH: begin
          ent_q   <= rom_data;
          retry_q <= '0;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (ent_q[23:8] == DELAY_REG) begin
            if (ent_q[7:0] == 8'h00) begin
              state_q <= S_NEXT;
            end else begin
              dly_q   <= dly_load_d;
              state_q <= S_DELAY;
            end
          end else begin
            register_q  <= ent_q[23:8];
            data_byte_q <= ent_q[7:0];
            start_en_q  <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          to_cnt_q <= '0;
          state_q  <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (busy) begin
            state_q <= S_WAIT_LO;
          end else if (to_cnt_q == TO_LAST) begin
            // Driver never acknowledged the start: handle like a NACK.
            err_flag_q <= 1'b1;
            state_q    <= S_CHECK;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        S_WAIT_LO: begin
          if (!busy) begin
            err_flag_q <= err;
            state_q    <= S_CHECK;
          end else begin
            state_q <= S_WAIT_LO;
          end
        end
        S_CHECK: begin
          gap_cnt_q <= '0;
          if (!err_flag_q) begin
            gap_retry_q <= 1'b0;
            state_q     <= S_GAP;
          end else if (retry_q < RTY_MAX) begin
            retry_q     <= retry_q + RTY_W'(1);
            gap_retry_q <= 1'b1;
            state_q     <= S_GAP;
          end else begin
            cfg_fail_q   <= 1'b1;
            fail_index_q <= idx_q;
            cfg_busy_q   <= 1'b0;
            state_q      <= S_FAIL;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            if (gap_retry_q) begin
              start_en_q <= 1'b1;
              state_q    <= S_ISSUE;
            end else begin
              state_q <= S_NEXT;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end
        S_DELAY: begin
          if (dly_q <= DLY_W'(1)) begin
            dly_q   <= '0;
            state_q <= S_NEXT;
          end else begin
            dly_q <= dly_q - DLY_W'(1);
          end
        end
        S_NEXT: begin
          if (idx_q == LAST_IDX) begin
            cfg_done_q <= 1'b1;
            cfg_busy_q <= 1'b0;
            state_q    <= S_DONE;
          end else begin
            idx_q      <= idx_inc_d;
            rom_addr_q <= idx_inc_d;
            state_q    <= S_FETCH;
          end
        end
        default: begin
          cfg_busy_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign rom_addr        = rom_addr_q;
  assign i2c_device_addr = DEV_ADDR;
  assign wr_rd_flag      = 1'b0;
  assign register        = register_q;
  assign data_byte       = data_byte_q;
  assign start_en        = start_en_q;
  assign cfg_busy        = cfg_busy_q;
  assign cfg_done        = cfg_done_q;
  assign cfg_fail        = cfg_fail_q;
  assign fail_index      = fail_index_q;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for cam_cfg_sequencer: a 3-entry table ROM, an I2C driver model
// with scriptable NACK/timeout behaviour, and a transaction-level reference
// model that derives the expected write sequence and final status.
// ---------------------------------------------------------------------------
module tb_cam_cfg_sequencer;

  localparam int NUM = 3;
  localparam int DT  = 10;
  localparam int MR  = 3;
  localparam int BT  = 64;
  localparam int GC  = 4;

  logic        clk_i     = 1'b0;
  logic        rst_n     = 1'b0;
  logic        cfg_start = 1'b0;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data  = 24'h0;
  logic [7:0]  i2c_device_addr;
  logic        wr_rd_flag;
  logic [15:0] register;
  logic [7:0]  data_byte;
  logic        start_en;
  logic        busy      = 1'b0;
  logic        err       = 1'b0;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_fail;
  logic [7:0]  fail_index;

  int checks = 0;
  int errors = 0;

  cam_cfg_sequencer #(
    .DEV_ADDR(8'h78), .NUM_ENTRIES(NUM), .ADDR_W(8), .MAX_RETRY(MR),
    .DELAY_TICKS(DT), .BUSY_TIMEOUT(BT), .GAP_CYCLES(GC)
  ) dut (
    .clk_i(clk_i), .rst_n(rst_n), .cfg_start(cfg_start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .i2c_device_addr(i2c_device_addr), .wr_rd_flag(wr_rd_flag),
    .register(register), .data_byte(data_byte), .start_en(start_en),
    .busy(busy), .err(err), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .cfg_fail(cfg_fail), .fail_index(fail_index)
  );

  always #5 clk_i = ~clk_i;

  // Cycle counter
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Synchronous table ROM
  logic [23:0] rom_tbl [0:NUM-1];
  always @(posedge clk_i) rom_data <= (rom_addr < 8'(NUM)) ? rom_tbl[rom_addr[1:0]] : 24'h0;

  // Driver model configuration (written by tests only)
  logic [15:0] nack_reg    = 16'h0;
  int          nack_times  = 0;
  int          nack_base   = 0;
  bit          drv_timeout = 1'b0;
  int          busy_min    = 3;
  int          busy_max    = 25;

  // Driver model state
  int   busy_left = 0;
  int   nack_seen = 0;
  logic pend_nack = 1'b0;
  int   last_fall = 0;

  // I2C driver model: busy for a random time, NACK the first nack_times
  // attempts on nack_reg, or never respond at all in timeout mode.
  always @(posedge clk_i) begin
    if (start_en && !drv_timeout) begin
      busy      <= 1'b1;
      err       <= 1'b0;
      busy_left <= int'($urandom_range(busy_max, busy_min));
      if (register == nack_reg) begin
        pend_nack <= ((nack_seen - nack_base) < nack_times);
        nack_seen <= nack_seen + 1;
      end else begin
        pend_nack <= 1'b0;
      end
    end else if (busy) begin
      if (busy_left <= 1) begin
        busy      <= 1'b0;
        err       <= pend_nack;
        last_fall <= cyc + 1;
      end else begin
        busy_left <= busy_left - 1;
      end
    end
  end

  // Transaction monitor
  logic [23:0] obs_q [$];
  int          obs_cyc [$];
  int          obs_gap [$];
  int          viol = 0;
  always @(negedge clk_i) begin
    if (start_en) begin
      obs_q.push_back({register, data_byte});
      obs_cyc.push_back(cyc);
      obs_gap.push_back(cyc - last_fall);
      if (busy) viol <= viol + 1;
    end
  end

  // Reference model: expected write attempts and final status of one run.
  logic [23:0] exp_q [$];
  bit          exp_done;
  int          exp_fidx;
  task automatic model_run();
    int nk;
    bit failed;
    exp_q = {};
    exp_done = 1'b1;
    exp_fidx = 0;
    nk = 0;
    failed = 1'b0;
    for (int i = 0; i < NUM && !failed; i++) begin
      if (rom_tbl[i][23:8] != 16'hFFFF) begin
        for (int a = 0; a <= MR; a++) begin
          bit bad;
          exp_q.push_back(rom_tbl[i]);
          bad = drv_timeout;
          if (rom_tbl[i][23:8] == nack_reg) begin
            if (nk < nack_times) bad = 1'b1;
            nk++;
          end
          if (!bad) break;
          if (a == MR) begin
            failed = 1'b1;
            exp_done = 1'b0;
            exp_fidx = i;
          end
        end
      end
    end
  endtask

  // Pulse cfg_start and wait (bounded) for done or fail.
  task automatic run_once(input int budget, output int base, output bit to);
    base = obs_q.size();
    nack_base = nack_seen;
    @(negedge clk_i); cfg_start = 1'b1;
    @(negedge clk_i); cfg_start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (cfg_done || cfg_fail) begin
        to = 1'b0;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({rom_addr, register, data_byte, start_en, cfg_busy, cfg_done, cfg_fail, fail_index} !== 44'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {rom_addr, register, data_byte, start_en, cfg_busy, cfg_done, cfg_fail, fail_index});
    end
    checks++;
    if ({i2c_device_addr, wr_rd_flag} !== {8'h78, 1'b0}) begin
      errors++;
      $display("FAIL reset_const: dev %h wr %b required 78 0", i2c_device_addr, wr_rd_flag);
    end
    rst_n = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_basic();
    logic [23:0] want [3];
    int base;
    bit to;
    want[0] = 24'h300882; want[1] = 24'h310303; want[2] = 24'h3017FF;
    for (int i = 0; i < NUM; i++) rom_tbl[i] = want[i];
    nack_times = 0; drv_timeout = 1'b0; busy_min = 20; busy_max = 20;
    run_once(3000, base, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_finish: run did not finish"); end
    checks++;
    if (obs_q.size() - base != 3) begin
      errors++; $display("FAIL basic_count: got %0d pulses required 3", obs_q.size() - base);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (base + i >= obs_q.size()) begin
        errors++; $display("FAIL basic_entry%0d: missing pulse", i);
      end else if (obs_q[base+i] !== want[i]) begin
        errors++; $display("FAIL basic_entry%0d: got %h required %h", i, obs_q[base+i], want[i]);
      end else if (i > 0 && obs_gap[base+i] < GC + 2) begin
        errors++; $display("FAIL basic_gap%0d: got %0d cycles required >= %0d", i, obs_gap[base+i], GC + 2);
      end
    end
    checks++;
    if ({cfg_done, cfg_busy, cfg_fail, fail_index} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL basic_status: done %b busy %b fail %b idx %0d required 1 0 0 0", cfg_done, cfg_busy, cfg_fail, fail_index);
    end
  endtask

  task automatic test_delay();
    int base, d, lo, hi;
    bit to;
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 0 : int'($urandom_range(4, 1));
      rom_tbl[0] = 24'h4000AA; rom_tbl[1] = {16'hFFFF, 8'(d)}; rom_tbl[2] = 24'h400155;
      nack_times = 0; drv_timeout = 1'b0; busy_min = 5; busy_max = 15;
      run_once(3000, base, to);
      lo = d * DT + GC;
      hi = d * DT + GC + 12;
      checks++;
      if (to || obs_q.size() - base != 2) begin
        errors++; $display("FAIL delay_count: got %0d pulses required 2 (timeout %b)", obs_q.size() - base, to);
      end else if (obs_q[base+1] !== 24'h400155) begin
        errors++; $display("FAIL delay_entry: got %h required 400155", obs_q[base+1]);
      end else if (obs_gap[base+1] < lo || obs_gap[base+1] > hi) begin
        errors++; $display("FAIL delay_gap: d=%0d got %0d cycles required %0d..%0d", d, obs_gap[base+1], lo, hi);
      end
      checks++;
      if (cfg_done !== 1'b1) begin errors++; $display("FAIL delay_done: got %b required 1", cfg_done); end
    end
  endtask

  task automatic test_nack_retry();
    int base, n1;
    bit to;
    rom_tbl[0] = 24'h300882; rom_tbl[1] = 24'h310303; rom_tbl[2] = 24'h3017FF;
    nack_reg = 16'h3103; nack_times = 2; drv_timeout = 1'b0; busy_min = 4; busy_max = 10;
    model_run();
    run_once(3000, base, to);
    n1 = 0;
    for (int i = base; i < obs_q.size(); i++) if (obs_q[i][23:8] == 16'h3103) n1++;
    checks++;
    if (n1 != 3) begin errors++; $display("FAIL retry_attempts: got %0d pulses for entry 1 required 3", n1); end
    checks++;
    if (obs_q.size() - base != exp_q.size()) begin
      errors++; $display("FAIL retry_count: got %0d required %0d", obs_q.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (obs_q[base+i] !== exp_q[i]) begin
          errors++; $display("FAIL retry_seq%0d: got %h required %h", i, obs_q[base+i], exp_q[i]);
          break;
        end
      end
    end
    checks++;
    if ({to, cfg_done, cfg_fail} !== 3'b010) begin
      errors++; $display("FAIL retry_status: timeout %b done %b fail %b required 0 1 0", to, cfg_done, cfg_fail);
    end
    nack_times = 0;
  endtask

  task automatic test_nack_fail();
    int base;
    bit to;
    nack_reg = 16'h3103; nack_times = 100; drv_timeout = 1'b0;
    run_once(3000, base, to);
    repeat (100) @(negedge clk_i);
    checks++;
    if (obs_q.size() - base != 5) begin
      errors++; $display("FAIL fail_count: got %0d pulses required 5", obs_q.size() - base);
    end
    checks++;
    if ({to, cfg_fail, cfg_done, cfg_busy, fail_index} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'd1}) begin
      errors++; $display("FAIL fail_status: to %b fail %b done %b busy %b idx %0d required 0 1 0 0 1", to, cfg_fail, cfg_done, cfg_busy, fail_index);
    end
    nack_times = 0;
  endtask

  task automatic test_timeout();
    int base, sp;
    bit to;
    rom_tbl[0] = 24'h5000C3;
    drv_timeout = 1'b1;
    run_once(3000, base, to);
    checks++;
    if (obs_q.size() - base != 4) begin
      errors++; $display("FAIL timeout_count: got %0d pulses required 4", obs_q.size() - base);
    end else begin
      for (int i = 1; i < 4; i++) begin
        sp = obs_cyc[base+i] - obs_cyc[base+i-1];
        if (sp < BT + GC || sp > BT + GC + 4 || obs_q[base+i] !== 24'h5000C3) begin
          errors++; $display("FAIL timeout_spacing%0d: got %0d cycles reg %h required %0d..%0d reg 5000c3", i, sp, obs_q[base+i], BT + GC, BT + GC + 4);
          break;
        end
      end
    end
    checks++;
    if ({to, cfg_fail, cfg_done, fail_index} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
      errors++; $display("FAIL timeout_status: to %b fail %b done %b idx %0d required 0 1 0 0", to, cfg_fail, cfg_done, fail_index);
    end
    drv_timeout = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int base;
    bit to;
    rom_tbl[0] = 24'h300882; rom_tbl[1] = 24'h310303; rom_tbl[2] = 24'h3017FF;
    busy_min = 30; busy_max = 30;
    base = obs_q.size();
    @(negedge clk_i); cfg_start = 1'b1;
    @(negedge clk_i); cfg_start = 1'b0;
    for (int i = 0; i < 500 && obs_q.size() < base + 2; i++) @(negedge clk_i);
    repeat (5) @(negedge clk_i);
    rst_n = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({busy, rom_addr, register, data_byte, start_en, cfg_busy, cfg_done, cfg_fail, fail_index} !== {1'b1, 44'h0}) begin
      errors++; $display("FAIL midrun_reset: busy %b outputs %h required busy 1 outputs 0", busy,
                         {rom_addr, register, data_byte, start_en, cfg_busy, cfg_done, cfg_fail, fail_index});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk_i);
    repeat (20) @(negedge clk_i);
    checks++;
    if (obs_q.size() - base != 2 || cfg_busy !== 1'b0) begin
      errors++; $display("FAIL midrun_abort: got %0d pulses busy %b required 2 pulses busy 0", obs_q.size() - base, cfg_busy);
    end
    busy_min = 6; busy_max = 12;
    base = obs_q.size();
    @(negedge clk_i); cfg_start = 1'b1;
    @(negedge clk_i); cfg_start = 1'b0;
    checks++;
    if ({cfg_busy, rom_addr} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL midrun_restart: busy %b rom_addr %0d required 1 0", cfg_busy, rom_addr);
    end
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 5 || i == 40) cfg_start = 1'b1;
      if (i == 6 || i == 41) cfg_start = 1'b0;
      if (cfg_done || cfg_fail) begin to = 1'b0; break; end
      @(negedge clk_i);
    end
    cfg_start = 1'b0;
    checks++;
    if (to || obs_q.size() - base != 3) begin
      errors++; $display("FAIL midrun_count: got %0d pulses required 3 (timeout %b)", obs_q.size() - base, to);
    end else if (obs_q[base] !== 24'h300882 || obs_q[base+1] !== 24'h310303 || obs_q[base+2] !== 24'h3017FF) begin
      errors++; $display("FAIL midrun_seq: got %h %h %h required 300882 310303 3017ff", obs_q[base], obs_q[base+1], obs_q[base+2]);
    end
    checks++;
    if (cfg_done !== 1'b1) begin errors++; $display("FAIL midrun_done: got %b required 1", cfg_done); end
  endtask

  task automatic test_random();
    int base, pick;
    bit to;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < NUM; i++) begin
        if ($urandom_range(3, 0) == 0) rom_tbl[i] = {16'hFFFF, 8'($urandom_range(3, 0))};
        else rom_tbl[i] = {16'($urandom_range(16'hFFFE, 0)), 8'($urandom)};
      end
      pick = int'($urandom_range(NUM - 1, 0));
      nack_reg = rom_tbl[pick][23:8];
      nack_times = (nack_reg == 16'hFFFF) ? 0 : int'($urandom_range(5, 0));
      drv_timeout = 1'b0; busy_min = 2; busy_max = 12;
      model_run();
      run_once(5000, base, to);
      checks++;
      if (to || obs_q.size() - base != exp_q.size()) begin
        errors++; $display("FAIL rand%0d_count: got %0d pulses required %0d (timeout %b)", it, obs_q.size() - base, exp_q.size(), to);
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          if (obs_q[base+i] !== exp_q[i]) begin
            errors++; $display("FAIL rand%0d_seq%0d: got %h required %h", it, i, obs_q[base+i], exp_q[i]);
            break;
          end
        end
      end
      checks++;
      if ({cfg_done, cfg_fail, fail_index} !== {exp_done, !exp_done, 8'(exp_fidx)}) begin
        errors++; $display("FAIL rand%0d_status: done %b fail %b idx %0d required %b %b %0d", it, cfg_done, cfg_fail, fail_index, exp_done, !exp_done, exp_fidx);
      end
    end
    nack_times = 0;
    checks++;
    if (viol != 0) begin errors++; $display("FAIL driver_contract: %0d start_en pulses while busy, required 0", viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay();
    test_nack_retry();
    test_nack_fail();
    test_timeout();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
